// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the memory dispatchers, the arbiter and one MCB user port.
// master = arbiter side, slave = requesters plus MCB command port side.
interface mem_port_arbiter_if;
    logic        mem_calib_done;

    logic        req0_valid;
    logic [2:0]  req0_instr;
    logic [5:0]  req0_bl;
    logic [29:0] req0_addr;
    logic        req0_release;
    logic        req0_ack;
    logic        gnt0;

    logic        req1_valid;
    logic [2:0]  req1_instr;
    logic [5:0]  req1_bl;
    logic [29:0] req1_addr;
    logic        req1_release;
    logic        req1_ack;
    logic        gnt1;

    logic        port_cmd_en;
    logic [2:0]  port_cmd_instr;
    logic [5:0]  port_cmd_bl;
    logic [29:0] port_cmd_byte_addr;
    logic        port_cmd_full;

    logic        timeout_err;

    modport master (
        input  mem_calib_done,
        input  req0_valid, req0_instr, req0_bl, req0_addr, req0_release,
        input  req1_valid, req1_instr, req1_bl, req1_addr, req1_release,
        input  port_cmd_full,
        output req0_ack, gnt0, req1_ack, gnt1,
        output port_cmd_en, port_cmd_instr, port_cmd_bl, port_cmd_byte_addr,
        output timeout_err
    );

    modport slave (
        output mem_calib_done,
        output req0_valid, req0_instr, req0_bl, req0_addr, req0_release,
        output req1_valid, req1_instr, req1_bl, req1_addr, req1_release,
        output port_cmd_full,
        input  req0_ack, gnt0, req1_ack, gnt1,
        input  port_cmd_en, port_cmd_instr, port_cmd_bl, port_cmd_byte_addr,
        input  timeout_err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for one MCB user port (c3_clk0 domain).
// Optional starvation guard for req1 enabled by defining ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
    parameter int OWN_TIMEOUT  = 1024,
    parameter int STARVE_LIMIT = 4,
    parameter int GAP_CYCLES   = 1
) (
    input  logic clk,
    input  logic reset_n,
    mem_port_arbiter_if.master bus
);

    localparam int TW = $clog2(OWN_TIMEOUT) + 1;
    localparam logic [TW-1:0] T_LAST = TW'(OWN_TIMEOUT - 1);
    localparam logic [1:0] G_LAST = 2'(GAP_CYCLES - 1);

    if (GAP_CYCLES < 0 || GAP_CYCLES > 3 || STARVE_LIMIT < 1 ||
        OWN_TIMEOUT < 2) begin : g_cfg_check
        $error("mem_port_arbiter: unsupported parameter set");
    end

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        OWN,
        GAP
    } state_t;

    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic          gnt_q, gnt_d;
    logic          en_q, en_d;
    logic          ack_q, ack_d;
    logic [2:0]    instr_q, instr_d;
    logic [5:0]    bl_q, bl_d;
    logic [29:0]   addr_q, addr_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [1:0]    gcnt_q, gcnt_d;
    logic          terr_q, terr_d;
    logic          pick1;
    logic          own_rel;

`ifdef ARB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] S_LIM = SW'(STARVE_LIMIT);

    logic [SW-1:0] starve_q, starve_d;

    // req1 wins when alone, or when req0 has beaten it S_LIM times in a row
    assign pick1 = bus.req1_valid &
                   (~bus.req0_valid | (starve_q >= S_LIM));

    // Consecutive req0 wins while req1 was waiting
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) starve_q <= '0;
        else          starve_q <= starve_d;
    end

    // Starvation count update, only on an IDLE arbitration
    always_comb begin
        starve_d = starve_q;
        if (state_q == IDLE && bus.mem_calib_done &&
            (bus.req0_valid || bus.req1_valid)) begin
            if (pick1)
                starve_d = '0;
            else if (bus.req1_valid && starve_q != S_LIM)
                starve_d = starve_q + 1'b1;
        end
    end
`else
    // Strict fixed priority: req1 only when req0 is idle
    assign pick1 = bus.req1_valid & ~bus.req0_valid;
`endif

    assign own_rel = owner_q ? bus.req1_release : bus.req0_release;

    // State and output registers; reset clears everything at once
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            gnt_q   <= 1'b0;
            en_q    <= 1'b0;
            ack_q   <= 1'b0;
            instr_q <= '0;
            bl_q    <= '0;
            addr_q  <= '0;
            tcnt_q  <= '0;
            gcnt_q  <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            gnt_q   <= gnt_d;
            en_q    <= en_d;
            ack_q   <= ack_d;
            instr_q <= instr_d;
            bl_q    <= bl_d;
            addr_q  <= addr_d;
            tcnt_q  <= tcnt_d;
            gcnt_q  <= gcnt_d;
            terr_q  <= terr_d;
        end
    end

    // Transaction sequencing: arbitrate, issue, own, gap
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        gnt_d   = gnt_q;
        en_d    = 1'b0;
        ack_d   = 1'b0;
        instr_d = instr_q;
        bl_d    = bl_q;
        addr_d  = addr_q;
        tcnt_d  = tcnt_q;
        gcnt_d  = gcnt_q;
        terr_d  = terr_q;
        unique case (state_q)
            IDLE: begin
                if (bus.mem_calib_done &&
                    (bus.req0_valid || bus.req1_valid)) begin
                    owner_d = pick1;
                    instr_d = pick1 ? bus.req1_instr : bus.req0_instr;
                    bl_d    = pick1 ? bus.req1_bl : bus.req0_bl;
                    addr_d  = pick1 ? bus.req1_addr : bus.req0_addr;
                    gnt_d   = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (!bus.port_cmd_full) begin
                    en_d    = 1'b1;
                    ack_d   = 1'b1;
                    tcnt_d  = '0;
                    state_d = OWN;
                end
            end
            OWN: begin
                if (own_rel || tcnt_q == T_LAST) begin
                    gnt_d   = 1'b0;
                    gcnt_d  = '0;
                    terr_d  = terr_q | ~own_rel;
                    state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            GAP: begin
                if (gcnt_q == G_LAST) state_d = IDLE;
                else                  gcnt_d  = gcnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.gnt0               = gnt_q & ~owner_q;
    assign bus.gnt1               = gnt_q & owner_q;
    assign bus.req0_ack           = ack_q & ~owner_q;
    assign bus.req1_ack           = ack_q & owner_q;
    assign bus.port_cmd_en        = en_q;
    assign bus.port_cmd_instr     = instr_q;
    assign bus.port_cmd_bl        = bl_q;
    assign bus.port_cmd_byte_addr = addr_q;
    assign bus.timeout_err        = terr_q;

endmodule
